cpu_jmp_ctrl: RTL and testbench
===============================

Name: cpu_jmp_ctrl

Overview:
- Control-flow stage directly upstream of the program counter in the one-cycle CPU.
- Decodes jump, conditional-jump, call and return strobes plus ALU flags, and drives the PC load strobe and load address.
- Holds a hardware return-address stack for CALL/RET, and reports full/empty status and a sticky stack-error flag.

Parameters:
- WIDTH, 8, address width; must match the PC width.
- DEPTH, 8, number of return-address stack entries; power of two, at least 2.
- SPW, 3, stack pointer width; equals log2(DEPTH).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- PC_IN  input  WIDTH  current PC value (PC output).
- TARGET  input  WIDTH  branch/call target from the instruction word.
- JMP  input  1  unconditional jump strobe.
- JZ  input  1  jump if Z_FLAG=1.
- JNZ  input  1  jump if Z_FLAG=0.
- JC  input  1  jump if C_FLAG=1.
- CALL  input  1  push return address, then jump to TARGET.
- RET  input  1  pop the stack and jump to the popped address.
- Z_FLAG  input  1  registered ALU zero flag.
- C_FLAG  input  1  registered ALU carry flag.
- LD  output  1  PC load strobe; combinational.
- ADDR  output  WIDTH  PC load address; combinational.
- SP  output  SPW+1  stack occupancy, 0..DEPTH; registered.
- FULL  output  1  SP==DEPTH.
- EMPTY  output  1  SP==0.
- ERR  output  1  sticky overflow/underflow flag; registered.

Behaviour:
- Reset: on a CLK edge with RST=1, SP=0, ERR=0, all stack entries cleared to 0. FULL=0 and EMPTY=1 follow from SP. While RST=1, LD=0 and ADDR=0, with no push or pop.
- Zero latency. LD/ADDR are combinational from the current strobes, flags, SP and top of stack, so the PC takes the new address on the same edge as the instruction.
- Priority when several strobes are high: RET > CALL > JMP > JC > JZ > JNZ. Lower strobes are ignored.
- JMP: LD=1, ADDR=TARGET.
- JC / JZ / JNZ: LD=1 and ADDR=TARGET only if the condition holds. Otherwise LD=0 and ADDR=TARGET (don't-care for the PC, but driven deterministically).
- CALL, not FULL:
  - LD=1, ADDR=TARGET.
  - On the edge: stack[SP] <= PC_IN+1 (mod 2^WIDTH, so 0xFF wraps to 0x00), SP <= SP+1.
- CALL when FULL:
  - No push, LD=0 (PC increments normally), ERR <= 1.
  - SP and stack are unchanged.
- RET, not EMPTY:
  - LD=1, ADDR=stack[SP-1].
  - On the edge: SP <= SP-1. The entry is not cleared.
- RET when EMPTY: LD=0, ADDR=0, ERR <= 1, SP stays 0.
- No strobe: LD=0, ADDR=0, state unchanged.
- ERR stays set until RST; further errors do not change it.
- Only one push or pop per cycle, so SP never moves by more than 1.
- RST asserted in the same cycle as CALL/RET: reset wins, no push/pop, ERR cleared.
- Stack storage is a register array, not inferred RAM, so the top-of-stack read is asynchronous.

Test Plan:
- Reset: RST=1 for 2 cycles with CALL=1, TARGET=0x40 -> LD=0, SP=0, EMPTY=1, ERR=0. After release, the first CALL works normally.
- Conditionals: Z=1 with JZ, TARGET=0x10 -> LD=1, ADDR=0x10. Z=1 with JNZ -> LD=0. C=0 with JC -> LD=0. JMP and JZ together with Z=0 -> LD=1 (JMP wins).
- Call/return: PC_IN=0x05, CALL, TARGET=0x20 -> LD=1, ADDR=0x20, SP=1 next cycle. Then PC_IN=0x2A with RET -> LD=1, ADDR=0x06, SP=0, EMPTY=1.
- Nesting and wrap: 3 CALLs from PC_IN=0x01, 0x21, 0xFF -> pushed 0x02, 0x22, 0x00. 3 RETs return ADDR=0x00, 0x22, 0x02 in that order.
- Overflow: DEPTH CALLs -> FULL=1. Next CALL -> LD=0, SP stays DEPTH, ERR=1. A following RET still returns the last valid entry.
- Underflow/sticky: RET with EMPTY=1 -> LD=0, ERR=1, SP=0. Valid CALL/RET afterwards keep ERR=1 until RST pulse clears it.

Source files
------------

// File: rtl/cpu_jmp_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_jmp_ctrl
//   Control-flow stage that sits directly in front of the program counter.
//   It decodes jump, conditional jump, call and return strobes together with
//   the ALU flags, and drives the PC load strobe and load address in the same
//   cycle as the instruction. A register-based return-address stack backs
//   CALL/RET.
//
//   Ports
//     CLK, RST          clock (rising edge), synchronous active-high reset
//     PC_IN             current PC value
//     TARGET            branch/call target from the instruction word
//     JMP/JZ/JNZ/JC     jump strobes (unconditional / Z=1 / Z=0 / C=1)
//     CALL, RET         push-and-jump / pop-and-jump strobes
//     Z_FLAG, C_FLAG    registered ALU flags
//     LD, ADDR          PC load strobe and address (combinational)
//     SP                stack occupancy 0..DEPTH (registered)
//     FULL, EMPTY       SP==DEPTH / SP==0
//     ERR               sticky overflow/underflow flag (registered)
// ---------------------------------------------------------------------------

// One return-address stack entry. Kept as plain flops so that the
// top-of-stack read is asynchronous.
module cpu_jmp_ctrl_ent #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] ent_q;

  always_ff @(posedge CLK) begin
    if (RST)       ent_q <= '0;
    else if (we_i) ent_q <= d_i;
  end

  assign q_o = ent_q;
endmodule

module cpu_jmp_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int SPW   = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] PC_IN,
  input  logic [WIDTH-1:0] TARGET,
  input  logic             JMP,
  input  logic             JZ,
  input  logic             JNZ,
  input  logic             JC,
  input  logic             CALL,
  input  logic             RET,
  input  logic             Z_FLAG,
  input  logic             C_FLAG,
  output logic             LD,
  output logic [WIDTH-1:0] ADDR,
  output logic [SPW:0]     SP,
  output logic             FULL,
  output logic             EMPTY,
  output logic             ERR
);

  logic [SPW:0]                sp_q, sp_d;
  logic                        err_q, err_d;
  logic [DEPTH-1:0][WIDTH-1:0] stk;
  logic [DEPTH-1:0]            we;
  logic [SPW-1:0]              wr_idx, rd_idx;
  logic [WIDTH-1:0]            ret_addr, tos;
  logic                        full, empty;
  logic                        push, pop, err_set;
  logic                        ld;
  logic [WIDTH-1:0]            addr;

  // Return address wraps modulo 2^WIDTH.
  assign ret_addr = PC_IN + WIDTH'(1);

  assign full  = (sp_q == (SPW+1)'(DEPTH));
  assign empty = (sp_q == '0);

  // Low SPW bits of SP index the next free slot; when SP==DEPTH they wrap to
  // 0, so rd_idx = wr_idx-1 still lands on the top entry (DEPTH-1).
  assign wr_idx = sp_q[SPW-1:0];
  assign rd_idx = wr_idx - SPW'(1);
  assign tos    = stk[rd_idx];

  // Strobe decode, priority RET > CALL > JMP > JC > JZ > JNZ.
  always_comb begin
    ld      = 1'b0;
    addr    = '0;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (RST) begin
      ld   = 1'b0;
      addr = '0;
    end else if (RET) begin
      if (empty) begin
        err_set = 1'b1;
      end else begin
        ld   = 1'b1;
        addr = tos;
        pop  = 1'b1;
      end
    end else if (CALL) begin
      addr = TARGET;
      if (full) begin
        // Let the PC increment past the CALL; flag the overflow.
        err_set = 1'b1;
      end else begin
        ld   = 1'b1;
        push = 1'b1;
      end
    end else if (JMP) begin
      ld   = 1'b1;
      addr = TARGET;
    end else if (JC) begin
      ld   = C_FLAG;
      addr = TARGET;
    end else if (JZ) begin
      ld   = Z_FLAG;
      addr = TARGET;
    end else if (JNZ) begin
      ld   = ~Z_FLAG;
      addr = TARGET;
    end
  end

  // At most one of push/pop per cycle, so SP moves by at most one.
  always_comb begin
    sp_d = sp_q;
    if (push)     sp_d = sp_q + (SPW+1)'(1);
    else if (pop) sp_d = sp_q - (SPW+1)'(1);
    err_d = err_q | err_set;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      we[i] = push && (wr_idx == SPW'(i));
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      cpu_jmp_ctrl_ent #(.WIDTH(WIDTH)) u_ent (
        .CLK  (CLK),
        .RST  (RST),
        .we_i (we[g]),
        .d_i  (ret_addr),
        .q_o  (stk[g])
      );
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  assign LD    = ld;
  assign ADDR  = addr;
  assign SP    = sp_q;
  assign FULL  = full;
  assign EMPTY = empty;
  assign ERR   = err_q;

endmodule

// File: tb/tb_cpu_jmp_ctrl.sv
module tb_cpu_jmp_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int SPW   = 3;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [WIDTH-1:0] PC_IN = '0, TARGET = '0;
  logic             JMP = 0, JZ = 0, JNZ = 0, JC = 0, CALL = 0, RET = 0;
  logic             Z_FLAG = 0, C_FLAG = 0;
  logic             LD;
  logic [WIDTH-1:0] ADDR;
  logic [SPW:0]     SP;
  logic             FULL, EMPTY, ERR;

  cpu_jmp_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SPW(SPW)) dut (
    .CLK(CLK), .RST(RST), .PC_IN(PC_IN), .TARGET(TARGET),
    .JMP(JMP), .JZ(JZ), .JNZ(JNZ), .JC(JC), .CALL(CALL), .RET(RET),
    .Z_FLAG(Z_FLAG), .C_FLAG(C_FLAG),
    .LD(LD), .ADDR(ADDR), .SP(SP), .FULL(FULL), .EMPTY(EMPTY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Reference model: a queue of return addresses plus a sticky error bit.
  logic [WIDTH-1:0] mstk[$];
  bit               merr;
  bit               known = 0;

  int n_tests = 0;
  int n_fail  = 0;

  logic             last_ld;
  logic [WIDTH-1:0] last_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One instruction cycle: drive inputs, check against the model, clock.
  task automatic cyc(input bit rst, call, ret, jmp, jc, jz, jnz, z, c,
                     input logic [WIDTH-1:0] pc, tgt);
    bit               e_ld, addr_chk, push, pop, eset;
    logic [WIDTH-1:0] e_addr;
    RST = rst; CALL = call; RET = ret; JMP = jmp; JC = jc; JZ = jz; JNZ = jnz;
    Z_FLAG = z; C_FLAG = c; PC_IN = pc; TARGET = tgt;
    #1;
    e_ld = 0; e_addr = '0; addr_chk = 1; push = 0; pop = 0; eset = 0;
    if (rst) begin
      e_ld = 0;
    end else if (ret) begin
      if (mstk.size() == 0) eset = 1;
      else begin e_ld = 1; e_addr = mstk[$]; pop = 1; end
    end else if (call) begin
      if (mstk.size() == DEPTH) begin eset = 1; addr_chk = 0; end
      else begin e_ld = 1; e_addr = tgt; push = 1; end
    end else if (jmp) begin
      e_ld = 1; e_addr = tgt;
    end else if (jc) begin
      e_ld = c; e_addr = tgt;
    end else if (jz) begin
      e_ld = z; e_addr = tgt;
    end else if (jnz) begin
      e_ld = !z; e_addr = tgt;
    end
    chk("LD", 32'(LD), 32'(e_ld));
    if (addr_chk) chk("ADDR", 32'(ADDR), 32'(e_addr));
    if (known) begin
      chk("SP",    32'(SP),    32'(mstk.size()));
      chk("FULL",  32'(FULL),  32'(mstk.size() == DEPTH));
      chk("EMPTY", 32'(EMPTY), 32'(mstk.size() == 0));
      chk("ERR",   32'(ERR),   32'(merr));
    end
    last_ld = LD; last_addr = ADDR;
    @(posedge CLK);
    if (rst) begin
      mstk.delete(); merr = 0; known = 1;
    end else begin
      if (push) mstk.push_back(WIDTH'((int'(pc) + 1) % (1 << WIDTH)));
      if (pop)  void'(mstk.pop_back());
      if (eset) merr = 1;
    end
    #1;
  endtask

  // shorthands: rst call ret jmp jc jz jnz z c pc tgt
  task automatic idle(); cyc(0,0,0,0,0,0,0,0,0,8'h00,8'h00); endtask
  task automatic do_call(input logic [7:0] pc, tgt); cyc(0,1,0,0,0,0,0,0,0,pc,tgt); endtask
  task automatic do_ret(input logic [7:0] pc); cyc(0,0,1,0,0,0,0,0,0,pc,8'h00); endtask
  task automatic do_rst(); cyc(1,0,0,0,0,0,0,0,0,8'h00,8'h00); endtask

  initial begin
    @(posedge CLK); #1;
    // Reset held for 2 cycles with CALL asserted: no load, no push.
    cyc(1,1,0,0,0,0,0,0,0,8'h05,8'h40);
    chk("rst_ld", 32'(last_ld), 32'd0);
    cyc(1,1,0,0,0,0,0,0,0,8'h05,8'h40);
    chk("rst_sp", 32'(SP), 32'd0);
    chk("rst_empty", 32'(EMPTY), 32'd1);
    chk("rst_err", 32'(ERR), 32'd0);
    // First CALL after release works.
    do_call(8'h05, 8'h20);
    chk("call_addr", 32'(last_addr), 32'h20);
    chk("call_sp", 32'(SP), 32'd1);
    do_ret(8'h2A);
    chk("ret_addr", 32'(last_addr), 32'h06);
    chk("ret_empty", 32'(EMPTY), 32'd1);

    // Conditionals and priority.
    cyc(0,0,0,0,0,1,0,1,0,8'h00,8'h10);
    chk("jz_taken", 32'(last_addr), 32'h10);
    cyc(0,0,0,0,0,0,1,1,0,8'h00,8'h10);
    chk("jnz_not", 32'(last_ld), 32'd0);
    cyc(0,0,0,0,1,0,0,0,0,8'h00,8'h10);
    chk("jc_not", 32'(last_ld), 32'd0);
    cyc(0,0,0,1,0,1,0,0,0,8'h00,8'h33);
    chk("jmp_wins", 32'(last_ld), 32'd1);

    // Nesting with address wrap.
    do_call(8'h01, 8'h50); do_call(8'h21, 8'h60); do_call(8'hFF, 8'h70);
    do_ret(8'h00); chk("nest0", 32'(last_addr), 32'h00);
    do_ret(8'h00); chk("nest1", 32'(last_addr), 32'h22);
    do_ret(8'h00); chk("nest2", 32'(last_addr), 32'h02);

    // Overflow.
    for (int i = 0; i < DEPTH; i++) do_call(8'(i * 3), 8'h80);
    chk("ovf_full", 32'(FULL), 32'd1);
    do_call(8'h77, 8'h90);
    chk("ovf_ld", 32'(last_ld), 32'd0);
    chk("ovf_sp", 32'(SP), 32'(DEPTH));
    chk("ovf_err", 32'(ERR), 32'd1);
    do_ret(8'h00);
    chk("ovf_ret", 32'(last_addr), 32'(8'((DEPTH - 1) * 3 + 1)));

    // Underflow and stickiness.
    do_rst();
    do_ret(8'h10);
    chk("udf_ld", 32'(last_ld), 32'd0);
    chk("udf_err", 32'(ERR), 32'd1);
    do_call(8'h10, 8'h30); do_ret(8'h30); idle();
    chk("sticky", 32'(ERR), 32'd1);
    do_rst(); idle();
    chk("err_clr", 32'(ERR), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 39) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          1'($urandom), 1'($urandom),
          8'($urandom), 8'($urandom));
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
